// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO channel: TX sequencer states and register map.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } tx_state_e;

  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;
  localparam int unsigned UART_BYTE_W    = 8;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; head reads 0 when empty.
module byte_fifo
  import uart_mmio_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = UART_BYTE_W,
  // When set, a push into a full FIFO succeeds if a pop happens in the same cycle.
  parameter bit          FULL_PASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || (FULL_PASS && do_pop));
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO channel: TX FIFO drained to the PHY by a launch/wait sequencer, RX FIFO
// filled from the PHY and popped by CPU loads, with a sticky RX overrun flag.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_we_i,
  input  logic [7:0] tx_data_i,
  input  logic       rx_re_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_busy_o,
  output logic       rx_overrun_o,
  input  logic       overrun_clr_i,
  output logic       phy_tx_start_o,
  output logic [7:0] phy_tx_byte_o,
  input  logic       phy_tx_busy_i,
  input  logic       phy_rx_done_i,
  input  logic [7:0] phy_rx_byte_i
);

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       overrun_q, overrun_d;

  logic       tx_full, tx_empty, tx_pop, tx_load;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty;
  logic [7:0] rx_head;

  byte_fifo #(
    .DEPTH     (TX_DEPTH),
    .WIDTH     (8),
    .FULL_PASS (1'b0)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_we_i),
    .wdata_i (tx_data_i),
    .pop_i   (tx_pop),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_head)
  );

  byte_fifo #(
    .DEPTH     (RX_DEPTH),
    .WIDTH     (8),
    .FULL_PASS (1'b1)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (phy_rx_done_i),
    .wdata_i (phy_rx_byte_i),
    .pop_i   (rx_re_i),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_byte_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      StIdle:     if (!tx_empty && !phy_tx_busy_i) tx_state_d = StLaunch;
      StLaunch:   tx_state_d = StWaitBusy;
      StWaitBusy: if (phy_tx_busy_i) tx_state_d = StWaitDone;
      StWaitDone: if (!phy_tx_busy_i) tx_state_d = StIdle;
      default:    tx_state_d = StIdle;
    endcase
  end

  // The byte is captured on entry to launch so it is already valid during the start strobe.
  always_comb begin
    tx_load        = (tx_state_q == StIdle) && !tx_empty && !phy_tx_busy_i;
    tx_pop         = (tx_state_q == StLaunch);
    phy_tx_start_o = (tx_state_q == StLaunch);
    tx_byte_d      = tx_load ? tx_head : tx_byte_q;
  end

  // Overrun set wins over a clear in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (phy_rx_done_i && rx_full && !rx_re_i) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  assign phy_tx_byte_o = tx_byte_q;
  assign rx_data_o     = rx_head;
  assign rx_valid_o    = !rx_empty;
  assign tx_busy_o     = tx_full;
  assign rx_overrun_o  = overrun_q;

endmodule
